// File: rtl/fetch_tx_inf_pkg.sv
// Shared definitions for the fetch serial line: default widths, line levels,
// minimum bit period and the FSM state encoding shared with the receiver bench.
package fetch_tx_inf_pkg;

  localparam int DW_DEF   = 16;
  localparam int TW_DEF   = 20;
  localparam int MIN_TBIT = 2;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/fetch_tx_inf_if.sv
// Valid/ready word handshake into the fetch transmitter.
interface fetch_tx_inf_if #(
  parameter int DW = 16
);

  logic [DW-1:0] tx_data;
  logic          tx_vld;
  logic          tx_rdy;

  modport master (output tx_data, output tx_vld, input tx_rdy);
  modport slave  (input tx_data, input tx_vld, output tx_rdy);

endinterface

// File: rtl/fetch_tx_inf_tbit_timer.sv
// Line bit timer: loads P on restart and strobes bit_end_o on the last clock
// of every P-clock bit while enabled.
module fetch_tbit_timer #(
  parameter int TW = 20
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          restart_i,
  input  logic [TW-1:0] period_i,
  output logic          bit_end_o
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] p_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      p_q   <= TW'(2);
    end else if (restart_i) begin
      p_q   <= period_i;
      cnt_q <= period_i - 1'b1;
    end else if (!en_i) begin
      cnt_q <= '0;
    end else if (cnt_q == '0) begin
      cnt_q <= p_q - 1'b1;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign bit_end_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/fetch_tx_inf.sv
// Fetch serial transmitter: one-word holding buffer, start/data/stop framing
// FSM and LSB-first shift register driving a registered idle-high line.
module fetch_tx_inf
  import fetch_tx_inf_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic [TW-1:0] tbit_period_i,
  fetch_tx_inf_if.slave bus,
  output logic          tx_o,
  output logic          tx_busy_o
);

  localparam int            IW       = $clog2(DW);
  localparam logic [TW-1:0] MIN_P    = TW'(MIN_TBIT);
  localparam logic [IW-1:0] LAST_IDX = IW'(DW - 1);

  logic [1:0]    state_q, state_d;
  logic          full_q, full_d;
  logic [DW-1:0] buf_q, buf_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tx_q, tx_d;
  logic          restart;
  logic          bit_end;
  logic [TW-1:0] period_clamped;

  assign period_clamped = (tbit_period_i < MIN_P) ? MIN_P : tbit_period_i;

  fetch_tbit_timer #(.TW(TW)) u_timer (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .en_i      (state_q != ST_IDLE),
    .restart_i (restart),
    .period_i  (period_clamped),
    .bit_end_o (bit_end)
  );

  // Accept needs an empty buffer and reload needs a full one, so they never collide.
  always_comb begin
    state_d = state_q;
    full_d  = full_q;
    buf_d   = buf_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    restart = 1'b0;

    if (bus.tx_vld && !full_q) begin
      full_d = 1'b1;
      buf_d  = bus.tx_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (full_q) restart = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_STOP;
            tx_d    = STOP_BIT;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      default: begin
        if (bit_end) begin
          if (full_q) begin
            restart = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = STOP_BIT;
          end
        end
      end
    endcase

    if (restart) begin
      state_d = ST_START;
      shift_d = buf_q;
      full_d  = 1'b0;
      idx_d   = '0;
      tx_d    = START_BIT;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      full_q  <= 1'b0;
      buf_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      buf_q   <= buf_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.tx_rdy = !full_q;
  assign tx_o       = tx_q;
  assign tx_busy_o  = (state_q != ST_IDLE);

endmodule
